// File: rtl/sweep_ctrl.sv
// sweep_ctrl: triangle sweep sequencer for the up/down counter datapath.
// Sweeps count between latched bounds lo..hi, one step per prescaler tick,
// in one-shot (lo->hi->lo) or continuous mode.
// Optional build macro SWEEP_PAUSE_EN adds a 'pause' input that freezes an
// active sweep (prescaler and count) while held high.
module sweep_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [PRESC_W-1:0] presc,
`ifdef SWEEP_PAUSE_EN
  input  logic               pause,
`endif
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               turn,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Configuration captured on an accepted start; the live inputs are ignored
  // for the rest of the sweep.
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [PRESC_W-1:0] presc_q;
  logic               cont_q;
  logic               load_cfg;

  logic [PRESC_W-1:0] pcnt;
  logic [PRESC_W-1:0] pcnt_nxt;
  logic               tick_c;
  logic               frozen_c;

  logic [WIDTH-1:0]   count_nxt;
  logic [WIDTH-1:0]   count_inc_c;
  logic [WIDTH-1:0]   count_dec_c;
  logic               dir_nxt;
  logic               done_nxt;
  logic               turn_nxt;
  logic               err_nxt;
  logic               cfg_bad_c;

  // Freeze request for an active sweep; tied off when the pause port is absent.
`ifdef SWEEP_PAUSE_EN
  assign frozen_c = pause;
`else
  assign frozen_c = 1'b0;
`endif

  // Prescaler terminal count and the two candidate step values.
  assign tick_c      = (pcnt == presc_q);
  assign count_inc_c = count + WIDTH'(1);
  assign count_dec_c = count - WIDTH'(1);
  assign cfg_bad_c   = (lo >= hi);

  // State, latched configuration, prescaler and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      presc_q <= '0;
      cont_q  <= 1'b0;
      pcnt    <= '0;
      count   <= '0;
      dir     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      turn    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      pcnt    <= pcnt_nxt;
      count   <= count_nxt;
      dir     <= dir_nxt;
      busy    <= (state_nxt != ST_IDLE);
      done    <= done_nxt;
      turn    <= turn_nxt;
      cfg_err <= err_nxt;
      if (load_cfg) begin
        lo_q    <= lo;
        hi_q    <= hi;
        presc_q <= presc;
        cont_q  <= mode_cont;
      end
    end
  end

  // Next-state and next-output decode; stop outranks both start and tick.
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    count_nxt = count;
    dir_nxt   = dir;
    done_nxt  = 1'b0;
    turn_nxt  = 1'b0;
    err_nxt   = 1'b0;
    load_cfg  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          if (cfg_bad_c) begin
            err_nxt = 1'b1;
          end else begin
            count_nxt = lo;
            dir_nxt   = 1'b1;
            pcnt_nxt  = '0;
            state_nxt = ST_UP;
          end
        end
      end

      ST_UP: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (!frozen_c) begin
          if (tick_c) begin
            pcnt_nxt  = '0;
            count_nxt = count_inc_c;
            if (count_inc_c == hi_q) begin
              dir_nxt   = 1'b0;
              turn_nxt  = 1'b1;
              state_nxt = ST_DOWN;
            end
          end else begin
            pcnt_nxt = pcnt + PRESC_W'(1);
          end
        end
      end

      ST_DOWN: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (!frozen_c) begin
          if (tick_c) begin
            pcnt_nxt  = '0;
            count_nxt = count_dec_c;
            if (count_dec_c == lo_q) begin
              if (cont_q) begin
                dir_nxt   = 1'b1;
                turn_nxt  = 1'b1;
                state_nxt = ST_UP;
              end else begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
              end
            end
          end else begin
            pcnt_nxt = pcnt + PRESC_W'(1);
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed bench for sweep_ctrl with a position-based sweep
// model and hand-written expectation tuples checked on every falling edge.
module tb_sweep_ctrl;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned PRESC_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic               mode_cont;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   hi;
  logic [PRESC_W-1:0] presc;
  logic               pause;
  logic [WIDTH-1:0]   count;
  logic               dir;
  logic               busy;
  logic               done;
  logic               turn;
  logic               cfg_err;

  sweep_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode_cont (mode_cont),
    .lo        (lo),
    .hi        (hi),
    .presc     (presc),
`ifdef SWEEP_PAUSE_EN
    .pause     (pause),
`endif
    .count     (count),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .turn      (turn),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;
  bit fin_chk  = 1'b0;

  // Hand-computed expectation tuples, one per falling edge once queued.
  typedef struct {
    bit care;
    bit cc;
    int cnt;
    bit cd;
    bit d;
    bit b;
    bit t;
    bit dn;
    bit er;
  } exp_t;

  exp_t lit_q[$];
  exp_t cur_e;

  function automatic exp_t mk(bit cc, int c, bit cd, bit d, bit b, bit t, bit dn, bit er);
    exp_t e;
    e.care = 1'b1; e.cc = cc; e.cnt = c; e.cd = cd; e.d = d;
    e.b = b; e.t = t; e.dn = dn; e.er = er;
    return e;
  endfunction

  // Pad with don't-care slots so the next push lands on sample k.
  task automatic pad_to(input int k);
    exp_t e;
    e = mk(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e.care = 1'b0;
    while (lit_q.size() < k - 1) lit_q.push_back(e);
  endtask

  // Sweep model: position along the triangle plus a tick countdown.
  bit m_run;
  bit m_cont;
  bit m_dir;
  bit m_turn;
  bit m_done;
  bit m_err;
  int m_count;
  int m_lo;
  int m_hi;
  int m_presc;
  int m_pos;
  int m_left;
  int m_span;
  bit m_pause;

  always @(posedge clk) begin
`ifdef SWEEP_PAUSE_EN
    m_pause = pause;
`else
    m_pause = 1'b0;
`endif
    m_turn = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_run   = 1'b0;
      m_count = 0;
      m_dir   = 1'b1;
    end else if (!m_run) begin
      if (start) begin
        if (int'(lo) >= int'(hi)) begin
          m_err = 1'b1;
        end else begin
          m_lo    = int'(lo);
          m_hi    = int'(hi);
          m_presc = int'(presc);
          m_cont  = mode_cont;
          m_run   = 1'b1;
          m_pos   = 0;
          m_left  = m_presc;
          m_count = m_lo;
          m_dir   = 1'b1;
        end
      end
    end else if (stop) begin
      m_run = 1'b0;
    end else if (!m_pause) begin
      if (m_left == 0) begin
        m_left = m_presc;
        m_span = m_hi - m_lo;
        m_pos  = m_pos + 1;
        if (m_pos == m_span) begin
          m_turn = 1'b1;
        end else if (m_pos == 2 * m_span) begin
          if (m_cont) begin
            m_pos  = 0;
            m_turn = 1'b1;
          end else begin
            m_done = 1'b1;
            m_run  = 1'b0;
          end
        end
        m_count = (m_pos <= m_span) ? m_lo + m_pos : m_lo + 2 * m_span - m_pos;
        m_dir   = (m_pos < m_span);
      end else begin
        m_left = m_left - 1;
      end
    end
  end

  task automatic cmp(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Compare process: model every cycle, literal tuples when queued.
  always @(negedge clk) begin
    if (armed) begin
      cmp("count", int'(count), m_count);
      cmp("dir", int'(dir), int'(m_dir));
      cmp("busy", int'(busy), int'(m_run));
      cmp("turn", int'(turn), int'(m_turn));
      cmp("done", int'(done), int'(m_done));
      cmp("cfg_err", int'(cfg_err), int'(m_err));
      if (lit_q.size() != 0) begin
        cur_e = lit_q.pop_front();
        if (cur_e.care) begin
          if (cur_e.cc) cmp("lit_count", int'(count), cur_e.cnt);
          if (cur_e.cd) cmp("lit_dir", int'(dir), int'(cur_e.d));
          cmp("lit_busy", int'(busy), int'(cur_e.b));
          cmp("lit_turn", int'(turn), int'(cur_e.t));
          cmp("lit_done", int'(done), int'(cur_e.dn));
          cmp("lit_cfg_err", int'(cfg_err), int'(cur_e.er));
        end
      end
      if (fin_chk) begin
        cmp("lit_queue_drained", lit_q.size(), 0);
        fin_chk = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  int seq[7];

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
    lo = '0; hi = '0; presc = '0; pause = 1'b0;
    step(1);
    armed = 1'b1;
    lit_q.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
    step(1);
    rst = 1'b0;
    step(2);

    // One-shot 2..5, tick every cycle.
    lo = 8'd2; hi = 8'd5; presc = '0; mode_cont = 1'b0;
    pulse_start();
    lit_q.push_back(mk(1, 2, 1, 1, 1, 0, 0, 0));
    lit_q.push_back(mk(1, 3, 1, 1, 1, 0, 0, 0));
    lit_q.push_back(mk(1, 4, 1, 1, 1, 0, 0, 0));
    lit_q.push_back(mk(1, 5, 1, 0, 1, 1, 0, 0));
    lit_q.push_back(mk(1, 4, 1, 0, 1, 0, 0, 0));
    lit_q.push_back(mk(1, 3, 1, 0, 1, 0, 0, 0));
    lit_q.push_back(mk(1, 2, 1, 0, 0, 0, 1, 0));
    lit_q.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0));
    step(10);

    // One-shot 0..3 with presc=3; live inputs scrambled after start.
    lo = 8'd0; hi = 8'd3; presc = 16'd3; mode_cont = 1'b0;
    pulse_start();
    lo = 8'd1; hi = 8'd200; presc = 16'd0; mode_cont = 1'b1;
    seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 2; seq[5] = 1; seq[6] = 0;
    for (int i = 0; i < 7; i++) begin
      for (int r = 0; r < ((i == 6) ? 1 : 4); r++) begin
        lit_q.push_back(mk(1, seq[i], 1, (i < 3), (i != 6), (i == 3 && r == 0), (i == 6), 0));
      end
    end
    lit_q.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
    step(30);

    // Continuous full range 0..255; start while busy is ignored.
    lo = 8'd0; hi = 8'd255; presc = '0; mode_cont = 1'b1;
    pulse_start();
    lit_q.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0));
    pad_to(256); lit_q.push_back(mk(1, 255, 1, 0, 1, 1, 0, 0));
    lit_q.push_back(mk(1, 254, 1, 0, 1, 0, 0, 0));
    pad_to(511); lit_q.push_back(mk(1, 0, 1, 1, 1, 1, 0, 0));
    lit_q.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0));
    pad_to(766); lit_q.push_back(mk(1, 255, 1, 0, 1, 1, 0, 0));
    step(100);
    start = 1'b1; lo = 8'd9; hi = 8'd20;
    step(1);
    start = 1'b0;
    step(667);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(3);

    // Rejected configurations; count and dir must hold.
    lo = 8'd5; hi = 8'd5;
    pulse_start();
    lit_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    lit_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    step(3);
    lo = 8'd7; hi = 8'd3;
    pulse_start();
    lit_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    lit_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    step(3);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);

    // Stop at count 4 on the down leg, then restart with start+stop together.
    lo = 8'd0; hi = 8'd10; presc = '0; mode_cont = 1'b0;
    pulse_start();
    pad_to(17); lit_q.push_back(mk(1, 4, 1, 0, 1, 0, 0, 0));
    lit_q.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0));
    lit_q.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0));
    step(16);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(3);
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    lit_q.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0));
    step(5);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(3);

    // Reset mid-sweep at count 6 overrides start and stop.
    lo = 8'd0; hi = 8'd10; mode_cont = 1'b1;
    pulse_start();
    pad_to(7); lit_q.push_back(mk(1, 6, 1, 1, 1, 0, 0, 0));
    lit_q.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
    step(6);
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    step(1);
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    step(3);

`ifdef SWEEP_PAUSE_EN
    // Pause ignored in IDLE; held 5 cycles at count 3; stop wins over pause.
    lo = 8'd0; hi = 8'd10; presc = '0; mode_cont = 1'b1;
    pause = 1'b1;
    pulse_start();
    pause = 1'b0;
    lit_q.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0));
    lit_q.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0));
    lit_q.push_back(mk(1, 2, 1, 1, 1, 0, 0, 0));
    for (int k = 0; k < 6; k++) lit_q.push_back(mk(1, 3, 1, 1, 1, 0, 0, 0));
    lit_q.push_back(mk(1, 4, 1, 1, 1, 0, 0, 0));
    step(3);
    pause = 1'b1;
    step(5);
    pause = 1'b0;
    step(4);
    pause = 1'b1; stop = 1'b1;
    step(1);
    pause = 1'b0; stop = 1'b0;
    step(3);
`endif

    fin_chk = 1'b1;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
Sequencer for the team's up/down counter datapath. Sweeps an internal WIDTH-bit count as a triangle between programmable bounds lo and hi, stepping once per prescaler tick. Drives count direction, supports one-shot and continuous modes, and hands status (busy/done/turn) to the surrounding control logic.

Parameters:
WIDTH, 8, width of count, lo, hi
PRESC_W, 16, width of prescaler reload and internal prescaler counter

Ports:
clk  input  1  clock
rst  input  1  reset
start  input  1  pulse; latch config, begin sweep (IDLE only)
stop  input  1  pulse; abort sweep
mode_cont  input  1  1 = continuous triangle, 0 = one-shot (lo→hi→lo)
lo  input  WIDTH  lower bound, unsigned
hi  input  WIDTH  upper bound, unsigned
presc  input  PRESC_W  tick every presc+1 clk cycles
count  output  WIDTH  current sweep value (registered)
dir  output  1  1 = counting up, 0 = counting down
busy  output  1  high in UP/DOWN
done  output  1  1-cycle pulse, one-shot sweep completed
turn  output  1  1-cycle pulse, direction reversal
cfg_err  output  1  1-cycle pulse, start rejected (lo >= hi)

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk. On reset: state IDLE, count=0, dir=1, busy=0, done=0, turn=0, cfg_err=0, prescaler counter=0.
- All outputs registered; done/turn/cfg_err high for exactly one cycle following the edge that sets them.
- States: IDLE, UP, DOWN. busy = (state != IDLE).
- IDLE, start=1: lo, hi, presc, mode_cont latched. If lo >= hi: cfg_err pulse, remain IDLE, count unchanged. Else: count<=lo, dir<=1, prescaler counter<=0, → UP.
- IDLE, start=0: count and dir hold last values.
- Tick: prescaler counter pcnt increments every cycle in UP/DOWN; when pcnt==presc_latched, tick asserted and pcnt<=0. presc=0 → tick every cycle. First tick presc+1 cycles after entering UP.
- UP, tick: count<=count+1. If count+1==hi: dir<=0, turn pulse, → DOWN.
- DOWN, tick: count<=count-1. If count-1==lo: continuous → dir<=1, turn pulse, → UP; one-shot → done pulse, → IDLE (no turn pulse), dir stays 0.
- Count never leaves [lo,hi]; no modular wrap even for lo=0 or hi=2^WIDTH-1.
- Full one-shot sweep: 2*(hi-lo) ticks; continuous period: 2*(hi-lo) ticks.
- stop in UP/DOWN: → IDLE next edge, count/dir hold, no done, no turn. stop in IDLE ignored.
- start in UP/DOWN ignored. start and stop in same cycle: in IDLE start acts; in UP/DOWN stop acts.
- Input changes on lo/hi/presc/mode_cont while busy have no effect (latched copies used).
- Reset mid-sweep: reset values next edge, overrides all other inputs.

Optional Feature:
SWEEP_PAUSE_EN. Defined: extra input port pause (1 bit). While pause=1 in UP/DOWN, prescaler counter and count frozen, no tick, state held; stop still honoured; pause ignored in IDLE. Undefined: port absent, sweep never freezes.

Test Plan:
- lo=2, hi=5, presc=0, mode_cont=0, start pulse → count 2,3,4,5,4,3,2 on consecutive edges; turn pulse with count=5; done pulse with count=2; busy low thereafter; dir 1→0.
- lo=0, hi=3, presc=3, one-shot → count changes every 4 cycles; first change to 1 exactly 4 cycles after start edge; sequence 0,1,2,3,2,1,0.
- WIDTH=8, lo=0, hi=255, presc=0, mode_cont=1 → triangle 0..255..0 repeating, turn pulses at 255 and 0, period 510 cycles, no wrap to 0 after 255, no done.
- lo=5, hi=5, start → cfg_err one cycle, busy stays 0, count unchanged; lo=7, hi=3 → same.
- lo=0, hi=10, presc=0, stop when count=4 on down leg → busy 0 next edge, count holds 4, no done; start again → count=0, UP.
- rst asserted mid-sweep (count=6) → next edge count=0, dir=1, busy=0, all pulses 0; with SWEEP_PAUSE_EN, pause held 5 cycles at count=3 → count stays 3, resumes stepping after release.
